// File: rtl/scan_disp_pkg.sv
// Shared definitions for the seven-segment scan-bus capture block.
// Holds the 4511-style segment patterns (bit 0 = a .. bit 6 = g), the error codes
// reported on err_type, the capture FSM encoding, and a helper that turns the
// active-low digit enables into an active-high one-hot-per-position vector.
package scan_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_6_ALT = 7'h7C;  // 6 without the top bar
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;  // 9 without the bottom bar
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned NUM_DIGITS = 4;

  // Sampled bus layout is {DG[1:4], seg[6:0]}; idle = no digit enabled, all segments off.
  localparam logic [10:0] IDLE_BUS = {4'b1111, SEG_BLANK};

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrMultiDg = 2'd1,
    ErrBadSeg  = 2'd2
  } err_type_e;

  typedef enum logic {
    StSettle = 1'b0,
    StHold   = 1'b1
  } cap_state_e;

  // Active-low DG[1:4] -> active-high vector indexed by position (0 = A .. 3 = D).
  function automatic logic [3:0] dg_active(logic [1:4] dg);
    logic [3:0] act;
    for (int p = 0; p < 4; p++) begin
      act[p] = ~dg[p+1];
    end
    return act;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment -> BCD decoder.
// Ports:
//   seg_i   [6:0]  segment pattern, bit 0 = a .. bit 6 = g, active-high
//   valid_o        pattern is a recognised digit or blank
//   blank_o        pattern is all-off (reported as digit 0)
//   bcd_o   [3:0]  decoded digit, 0 when invalid or blank
module seg7_to_bcd
  import scan_disp_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic       blank_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    valid_o = 1'b1;
    blank_o = 1'b0;
    bcd_o   = 4'd0;
    case (seg_i)
      SEG_BLANK:          blank_o = 1'b1;
      SEG_0:              bcd_o   = 4'd0;
      SEG_1:              bcd_o   = 4'd1;
      SEG_2:              bcd_o   = 4'd2;
      SEG_3:              bcd_o   = 4'd3;
      SEG_4:              bcd_o   = 4'd4;
      SEG_5:              bcd_o   = 4'd5;
      SEG_6, SEG_6_ALT:   bcd_o   = 4'd6;
      SEG_7:              bcd_o   = 4'd7;
      SEG_8:              bcd_o   = 4'd8;
      SEG_9, SEG_9_ALT:   bcd_o   = 4'd9;
      default:            valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/scan_display_capture.sv
// Receive side of a 4-digit multiplexed seven-segment bus. The scanned bus is sampled
// every clock; a (DG, seg) pair is accepted once it has been identical for STABLE_CYC
// samples, which filters the glitches around scan edges. Accepted digits are decoded
// back to BCD into a shadow frame; once all four positions have been seen the shadow
// is copied to the outputs and frame_valid pulses. A partial frame older than
// TIMEOUT_CYC clocks is discarded and flagged as stale.
// Ports:
//   Clk, Aclr            clock (rising edge), synchronous active-high reset
//   DG_in  [1:4]         active-low digit enables, DG_in[1] = A .. DG_in[4] = D
//   seg_in [7:0]         segments a..g in [6:0], dp in [7] (ignored)
//   A_out..D_out [3:0]   BCD digits of the last complete frame
//   blank  [3:0]         {D,C,B,A} position was blank in the last frame
//   frame_valid          one-cycle pulse when the digit outputs take a new frame
//   stale                set on timeout, cleared with the next frame_valid
//   err, err_type [1:0]  one-cycle error pulse with cause (1 = multi DG, 2 = bad pattern)
module scan_display_capture
  import scan_disp_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic       Clk,
  input  logic       Aclr,
  input  logic [1:4] DG_in,
  input  logic [7:0] seg_in,
  output logic [3:0] A_out,
  output logic [3:0] B_out,
  output logic [3:0] C_out,
  output logic [3:0] D_out,
  output logic [3:0] blank,
  output logic       frame_valid,
  output logic       stale,
  output logic       err,
  output logic [1:0] err_type
);

  localparam int unsigned StabW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int unsigned ToW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Stability count seen on the edge that accepts: the compare on that edge makes it
  // STABLE_CYC-1.
  localparam logic [StabW-1:0] StabAccept = StabW'(STABLE_CYC - 2);
  localparam logic [ToW-1:0]   ToLast     = ToW'(TIMEOUT_CYC - 1);

  // Sample and compare registers.
  logic [10:0] smp_q, smp_d, cmp_q, cmp_d;

  // Acceptance FSM and counters.
  cap_state_e       state_q, state_d;
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;

  // Frame under construction.
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  shadow_bcd_q, shadow_bcd_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic             complete_q, complete_d;

  // Registered outputs.
  logic [3:0][3:0]  out_bcd_q, out_bcd_d;
  logic [3:0]       out_blank_q, out_blank_d;
  logic             frame_valid_q, frame_valid_d;
  logic             stale_q, stale_d;
  logic             err_q, err_d;
  err_type_e        err_type_q, err_type_d;

  logic       unused_dp;
  logic       same;
  logic       accept;
  logic [3:0] dg_low;
  logic       dg_none;
  logic       dg_one;
  logic       wr_en;
  logic       timeout;
  logic [3:0] seen_set;
  logic       dec_valid;
  logic       dec_blank;
  logic [3:0] dec_bcd;

  assign unused_dp = seg_in[7];

  seg7_to_bcd u_seg7_to_bcd (
    .seg_i   (smp_q[6:0]),
    .valid_o (dec_valid),
    .blank_o (dec_blank),
    .bcd_o   (dec_bcd)
  );

  // Sampling and stability filter.
  always_comb begin
    smp_d      = {DG_in, seg_in[6:0]};
    cmp_d      = smp_q;
    same       = (smp_q == cmp_q);
    accept     = 1'b0;
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    unique case (state_q)
      StSettle: begin
        if (same) begin
          stab_cnt_d = stab_cnt_q + 1'b1;
          if (stab_cnt_q == StabAccept) begin
            accept  = 1'b1;
            state_d = StHold;
          end
        end else begin
          stab_cnt_d = '0;
        end
      end
      // Pair already taken; wait for the bus to move before arming again.
      StHold: begin
        if (!same) begin
          state_d    = StSettle;
          stab_cnt_d = '0;
        end
      end
    endcase
  end

  // Classification of the accepted pair.
  always_comb begin
    dg_low  = dg_active(smp_q[10:7]);
    dg_none = (dg_low == 4'd0);
    dg_one  = !dg_none && ((dg_low & (dg_low - 4'd1)) == 4'd0);
    wr_en   = accept && dg_one && dec_valid;
    // All-high DG is inter-digit blanking and is silently dropped.
    err_d   = accept && !dg_none && !(dg_one && dec_valid);
    if (!err_d) begin
      err_type_d = ErrNone;
    end else if (dg_one) begin
      err_type_d = ErrBadSeg;
    end else begin
      err_type_d = ErrMultiDg;
    end
  end

  // Shadow frame, completion and timeout.
  always_comb begin
    shadow_bcd_d   = shadow_bcd_q;
    shadow_blank_d = shadow_blank_q;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (wr_en && dg_low[p]) begin
        shadow_bcd_d[p]   = dec_bcd;
        shadow_blank_d[p] = dec_blank;
      end
    end

    seen_set   = seen_q | (wr_en ? dg_low : 4'd0);
    complete_d = wr_en && (seen_set == 4'b1111);
    // A write on this edge restarts the count, so completion always beats timeout.
    timeout    = !wr_en && (to_cnt_q == ToLast);

    if (complete_d || timeout) begin
      seen_d = '0;
    end else begin
      seen_d = seen_set;
    end

    if (wr_en || timeout) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Output stage: publish the shadow one edge after the frame completes.
  always_comb begin
    frame_valid_d = complete_q;
    out_bcd_d     = out_bcd_q;
    out_blank_d   = out_blank_q;
    stale_d       = stale_q;
    if (complete_q) begin
      out_bcd_d   = shadow_bcd_q;
      out_blank_d = shadow_blank_q;
      stale_d     = 1'b0;
    end else if (timeout) begin
      stale_d     = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Aclr) begin
      smp_q          <= IDLE_BUS;
      cmp_q          <= IDLE_BUS;
      state_q        <= StSettle;
      stab_cnt_q     <= '0;
      to_cnt_q       <= '0;
      seen_q         <= '0;
      shadow_bcd_q   <= '0;
      shadow_blank_q <= '0;
      complete_q     <= 1'b0;
      out_bcd_q      <= '0;
      out_blank_q    <= '0;
      frame_valid_q  <= 1'b0;
      stale_q        <= 1'b0;
      err_q          <= 1'b0;
      err_type_q     <= ErrNone;
    end else begin
      smp_q          <= smp_d;
      cmp_q          <= cmp_d;
      state_q        <= state_d;
      stab_cnt_q     <= stab_cnt_d;
      to_cnt_q       <= to_cnt_d;
      seen_q         <= seen_d;
      shadow_bcd_q   <= shadow_bcd_d;
      shadow_blank_q <= shadow_blank_d;
      complete_q     <= complete_d;
      out_bcd_q      <= out_bcd_d;
      out_blank_q    <= out_blank_d;
      frame_valid_q  <= frame_valid_d;
      stale_q        <= stale_d;
      err_q          <= err_d;
      err_type_q     <= err_type_d;
    end
  end

  assign A_out       = out_bcd_q[0];
  assign B_out       = out_bcd_q[1];
  assign C_out       = out_bcd_q[2];
  assign D_out       = out_bcd_q[3];
  assign blank       = out_blank_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;
  assign err         = err_q;
  assign err_type    = err_type_q;

endmodule

// File: tb/tb_scan_display_capture.sv
// Scoreboard bench for scan_display_capture. A reference model, driven by the same
// input stream at every rising edge, decides when a bus value has been steady long
// enough, decodes it from a pattern table and queues the expected frame/error events
// with the cycle they must appear on. A monitor on the falling edge pops and compares.
module tb_scan_display_capture;

  localparam int unsigned STABLE  = 4;
  localparam int unsigned TIMEOUT = 65536;

  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       Clk = 1'b0;
  logic       Aclr;
  logic [1:4] DG_in;
  logic [7:0] seg_in;
  logic [3:0] A_out, B_out, C_out, D_out, blank;
  logic       frame_valid, stale, err;
  logic [1:0] err_type;

  always #5 Clk = ~Clk;

  scan_display_capture #(
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .Aclr        (Aclr),
    .DG_in       (DG_in),
    .seg_in      (seg_in),
    .A_out       (A_out),
    .B_out       (B_out),
    .C_out       (C_out),
    .D_out       (D_out),
    .blank       (blank),
    .frame_valid (frame_valid),
    .stale       (stale),
    .err         (err),
    .err_type    (err_type)
  );

  typedef struct packed {
    logic [3:0] a, b, c, d;
    logic [3:0] blk;
  } frame_t;

  typedef struct {
    int     cyc;
    frame_t f;
  } frame_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] t;
  } err_exp_t;

  frame_exp_t frame_q[$];
  err_exp_t   err_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state.
  bit         rst_edge;
  logic [1:4] run_dg;
  logic [6:0] run_seg;
  int         run_len;
  bit         run_acc;
  logic [3:0] shadow [4];
  logic [3:0] sblk;
  logic [3:0] seen;
  int         since;
  bit         exp_stale;
  bit         pend_clear;

  // Monitor state.
  frame_t cur_frame;
  logic   prev_stale;
  bit     prev_exp_stale;

  function automatic bit ref_decode(input logic [6:0] s, output int val, output bit blk);
    val = 0;
    blk = 1'b0;
    if (s == 7'h00) begin
      blk = 1'b1;
      return 1'b1;
    end
    for (int d = 0; d < 10; d++) begin
      if (s == PAT[d]) begin
        val = d;
        return 1'b1;
      end
    end
    if (s == 7'h7C) begin
      val = 6;
      return 1'b1;
    end
    if (s == 7'h67) begin
      val = 9;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d: got none/extra event, expected match", name, cyc);
  endtask

  task automatic model_step();
    int         nlow;
    int         pos;
    int         v;
    bit         blk;
    bit         wr;
    frame_exp_t fe;
    err_exp_t   ee;
    cyc++;
    rst_edge = Aclr;
    if (Aclr) begin
      run_dg     = 4'b1111;
      run_seg    = 7'h00;
      run_len    = STABLE;
      run_acc    = 1'b1;
      for (int p = 0; p < 4; p++) shadow[p] = 4'd0;
      sblk       = 4'd0;
      seen       = 4'd0;
      since      = 0;
      exp_stale  = 1'b0;
      pend_clear = 1'b0;
      frame_q.delete();
      err_q.delete();
      return;
    end
    wr = 1'b0;
    if (pend_clear) begin
      exp_stale  = 1'b0;
      pend_clear = 1'b0;
    end
    // A value seen on STABLE consecutive edges is taken on the next edge, once per run.
    if (run_len == STABLE && !run_acc) begin
      run_acc = 1'b1;
      nlow = 0;
      pos  = 0;
      for (int p = 0; p < 4; p++) begin
        if (run_dg[p+1] == 1'b0) begin
          nlow++;
          pos = p;
        end
      end
      if (nlow > 1) begin
        ee.cyc = cyc;
        ee.t   = 2'd1;
        err_q.push_back(ee);
      end else if (nlow == 1) begin
        if (ref_decode(run_seg, v, blk)) begin
          shadow[pos] = v[3:0];
          sblk[pos]   = blk;
          seen[pos]   = 1'b1;
          wr          = 1'b1;
          if (seen == 4'b1111) begin
            fe.cyc = cyc + 1;
            fe.f   = '{a: shadow[0], b: shadow[1], c: shadow[2], d: shadow[3], blk: sblk};
            frame_q.push_back(fe);
            seen       = 4'd0;
            pend_clear = 1'b1;
          end
        end else begin
          ee.cyc = cyc;
          ee.t   = 2'd2;
          err_q.push_back(ee);
        end
      end
    end
    if (wr) begin
      since = 0;
    end else begin
      since++;
      if (since == TIMEOUT) begin
        seen      = 4'd0;
        exp_stale = 1'b1;
        since     = 0;
      end
    end
    if (DG_in == run_dg && seg_in[6:0] == run_seg) begin
      if (run_len < STABLE) run_len++;
    end else begin
      run_dg  = DG_in;
      run_seg = seg_in[6:0];
      run_len = 1;
      run_acc = 1'b0;
    end
  endtask

  task automatic monitor_step();
    frame_t got;
    got = '{a: A_out, b: B_out, c: C_out, d: D_out, blk: blank};
    if (rst_edge) begin
      check("reset_state", 32'({got, frame_valid, stale, err, err_type}), 32'd0);
      cur_frame      = '0;
      prev_stale     = 1'b0;
      prev_exp_stale = 1'b0;
      return;
    end
    while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
      fail_event("err_missing");
      void'(err_q.pop_front());
    end
    if (err === 1'b1) begin
      if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
        check("err_type", 32'(err_type), 32'(err_q[0].t));
        void'(err_q.pop_front());
      end else begin
        fail_event("err_unexpected");
      end
    end
    while (frame_q.size() > 0 && frame_q[0].cyc < cyc) begin
      fail_event("frame_missing");
      void'(frame_q.pop_front());
    end
    if (frame_valid === 1'b1) begin
      if (frame_q.size() > 0 && frame_q[0].cyc == cyc) begin
        check("frame_digits", 32'(got), 32'(frame_q[0].f));
        cur_frame = frame_q[0].f;
        void'(frame_q.pop_front());
      end else begin
        fail_event("frame_unexpected");
      end
    end
    if (stale !== prev_stale || exp_stale != prev_exp_stale) begin
      check("stale", 32'(stale), 32'(exp_stale));
      check("outputs_held", 32'(got), 32'(cur_frame));
    end
    prev_stale     = stale;
    prev_exp_stale = exp_stale;
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    monitor_step();
  end

  task automatic drive(input logic [1:4] dg, input logic [7:0] seg, input int n);
    DG_in  = dg;
    seg_in = seg;
    repeat (n) @(negedge Clk);
  endtask

  task automatic show(input int p, input logic [6:0] s, input int n);
    logic [1:4] dg;
    dg      = 4'b1111;
    dg[p+1] = 1'b0;
    drive(dg, {1'b0, s}, n);
  endtask

  task automatic scan(input logic [6:0] sa, input logic [6:0] sb, input logic [6:0] sc,
                      input logic [6:0] sd, input int n);
    show(0, sa, n);
    show(1, sb, n);
    show(2, sc, n);
    show(3, sd, n);
  endtask

  initial begin
    Aclr   = 1'b1;
    DG_in  = 4'b1111;
    seg_in = 8'h00;
    repeat (3) @(negedge Clk);
    Aclr = 1'b0;
    drive(4'b1111, 8'h00, 4);

    // Plain 1-2-3-4 scans.
    repeat (3) scan(7'h06, 7'h5B, 7'h4F, 7'h66, 8);

    // Two-cycle 8 glitch inside digit A must not be captured.
    show(0, 7'h06, 5);
    show(0, 7'h7F, 2);
    show(0, 7'h06, 5);
    show(1, 7'h6D, 8);
    show(2, 7'h07, 8);
    show(3, 7'h3F, 8);

    // Two digit enables at once.
    drive(4'b0011, 8'h06, 8);
    // Undecodable pattern, then alternate 6 and 9 forms plus a blank position.
    show(0, 7'h49, 8);
    scan(7'h7C, 7'h67, 7'h00, 7'h7D, 8);

    // Randomised scanning with glitches, stray DG values and odd dwell times.
    for (int i = 0; i < 240; i++) begin
      int         p;
      int         d;
      int         r;
      logic [7:0] s;
      logic [1:4] dg;
      p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : (i % 4);
      d = $urandom_range(0, 9);
      s = {1'($urandom_range(0, 1)), PAT[d]};
      if (d == 6 && $urandom_range(0, 1) == 1) s[6:0] = 7'h7C;
      if (d == 9 && $urandom_range(0, 1) == 1) s[6:0] = 7'h67;
      r = $urandom_range(0, 15);
      if (r == 0) s[6:0] = 7'h00;
      if (r == 1) s[6:0] = 7'($urandom);
      dg      = 4'b1111;
      dg[p+1] = 1'b0;
      if (r == 2) dg = 4'($urandom);
      drive(dg, s, $urandom_range(2, 9));
      if ($urandom_range(0, 2) == 0) drive(4'b1111, 8'h00, $urandom_range(1, 3));
    end
    scan(7'h4F, 7'h3F, 7'h7F, 7'h06, 8);

    // Scan stops after two digits: timeout, then a full scan recovers.
    show(0, 7'h66, 8);
    show(1, 7'h5B, 8);
    drive(4'b1111, 8'h00, TIMEOUT + 20);
    scan(7'h07, 7'h6F, 7'h06, 7'h3F, 8);

    // Reset after three digits; the next frame needs all four again.
    show(0, 7'h6D, 8);
    show(1, 7'h66, 8);
    show(2, 7'h4F, 8);
    drive(4'b1111, 8'h00, 1);
    Aclr = 1'b1;
    @(negedge Clk);
    Aclr = 1'b0;
    show(3, 7'h7F, 8);
    scan(7'h5B, 7'h06, 7'h07, 7'h6D, 8);
    drive(4'b1111, 8'h00, 20);

    while (frame_q.size() > 0) begin
      fail_event("frame_never_seen");
      void'(frame_q.pop_front());
    end
    while (err_q.size() > 0) begin
      fail_event("err_never_seen");
      void'(err_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
